seq_adder: RTL
==============

SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1, bits added per clock; SHALL divide WIDTH exactly, so N = WIDTH/DIGIT is the run length.
REQ-003 iClk  input  1  single clock; all state changes on the rising edge.
REQ-004 iRst  input  1  reset, synchronous and active-high.
REQ-005 iStart  input  1  request; sampled only in IDLE or DONE.
REQ-006 iA  input  WIDTH  operand A; captured on the accepting edge.
REQ-007 iB  input  WIDTH  operand B; captured on the accepting edge.
REQ-008 iC  input  1  carry-in; captured on the accepting edge.
REQ-009 iSub  input  1  mode, 0 = add, 1 = subtract; captured on the accepting edge.
REQ-010 oBusy  output  1  high while in RUN.
REQ-011 oDone  output  1  one-cycle pulse marking a new valid result.
REQ-012 oS  output  WIDTH  registered sum/difference.
REQ-013 oC  output  1  registered carry-out; in subtract mode 1 = no borrow.
REQ-014 oV  output  1  registered two's-complement overflow.

Function
REQ-015 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on iStart=1.
- RUN->DONE after the N-th processing edge.
- DONE->RUN on iStart=1, else DONE->IDLE.
REQ-016 Accepting edge actions: latch A, effective B = iSub ? ~iB : iB, and carry register = iC ^ iSub; clear digit counter to 0.
REQ-017 Each RUN edge: add digit k of A, B and the carry register (DIGIT-bit ripple add); store DIGIT sum bits into internal result bits [k*DIGIT +: DIGIT]; store carry-out in the carry register; increment k.
REQ-018 Carries only propagate through the carry register between cycles; no full-width combinational adder.
REQ-019 On the N-th RUN edge, also load the outputs:
- oS = complete result;
- oC = final carry-out;
- oV = carry into bit WIDTH-1 XOR final carry-out.
REQ-020 oS, oC and oV SHALL change only on entry to DONE or on reset; they hold their values through IDLE and the next RUN.
REQ-021 oDone SHALL be 1 exactly in the cycle after the N-th RUN edge (DONE state), and 0 otherwise.
REQ-022 Latency: oDone is visible N rising edges after the accepting edge.
REQ-023 Throughput: iStart=1 while in DONE is accepted, giving back-to-back operations with one result every N+1 cycles.
REQ-024 iStart during RUN SHALL be ignored, and operand changes during RUN SHALL have no effect.
REQ-025 Arithmetic is modulo 2^WIDTH; oS wraps with no saturation.

Reset
REQ-026 iRst=1 at a rising edge forces: state IDLE, counter 0, carry register 0, oS=0, oC=0, oV=0, oBusy=0, oDone=0.
REQ-027 iRst takes priority over iStart on the same edge.
REQ-028 Reset mid-RUN aborts the operation: no oDone is produced and the outputs are zeroed.

Verification (WIDTH=8, DIGIT=1 unless noted)
REQ-029 A=0x3C, B=0x05, C=0, Sub=0 -> oDone 8 edges after accept; oS=0x41, oC=0, oV=0; oBusy high for exactly 8 cycles.
REQ-030 A=0xFF, B=0x01, C=0, Sub=0 -> oS=0x00, oC=1, oV=0.
REQ-031 A=0x7F, B=0x01, C=0, Sub=0 -> oS=0x80, oC=0, oV=1.
REQ-032 A=0x05, B=0x07, C=0, Sub=1 -> oS=0xFE, oC=0 (borrow), oV=0; then with iStart held high in DONE, second op A=0x10, B=0x01, Sub=1 -> oS=0x0F, oC=1, with oDone pulses 9 cycles apart.
REQ-033 Two cases:
- iStart re-pulsed with new operands in RUN cycle 3 -> ignored, original result produced.
- iRst in RUN cycle 4 -> all outputs 0, no oDone; the next start completes normally.
REQ-034 DIGIT=4: A=0x99, B=0x67, C=1, Sub=0 -> oDone 2 edges after accept; oS=0x01, oC=1, oV=0.

Source files
------------

// File: rtl/seq_adder.sv
// Digit-serial adder/subtractor.
// Accepts two WIDTH-bit operands, adds DIGIT bits per clock and
// presents the registered sum, carry-out and overflow on entry to DONE.
// The carry between digits lives only in cy_q; there is no full-width adder.
module seq_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  input  logic             iSub,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oS,
  output logic             oC,
  output logic             oV
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             cy_q;

  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             v_q;
  logic             busy_q;
  logic             done_q;

  logic [DIGIT-1:0] sum_d;
  logic [WIDTH-1:0] res_d;
  logic             ripple_d;
  logic             cout_d;
  logic             cmsb_d;

  // Ripple-add the current low digit of A and B with the carry register.
  // Operands are shifted right each RUN edge, so the active digit is always
  // at bits [DIGIT-1:0]; result digits enter from the top, which places
  // digit k at [k*DIGIT +: DIGIT] once all N digits have been shifted in.
  always_comb begin
    sum_d    = '0;
    cmsb_d   = 1'b0;
    ripple_d = cy_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) begin
        cmsb_d = ripple_d;
      end
      sum_d[i] = a_q[i] ^ b_q[i] ^ ripple_d;
      ripple_d = (a_q[i] & b_q[i]) | (ripple_d & (a_q[i] ^ b_q[i]));
    end
    cout_d = ripple_d;
    res_d  = (res_q >> DIGIT) | (WIDTH'(sum_d) << (WIDTH - DIGIT));
  end

  // Control FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          res_q <= res_d;
          cy_q  <= cout_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            s_q     <= res_d;
            c_q     <= cout_d;
            v_q     <= cmsb_d ^ cout_d;
          end
        end
        // IDLE and DONE both accept a new request; otherwise rest in IDLE.
        default: begin
          done_q <= 1'b0;
          if (iStart) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            a_q     <= iA;
            b_q     <= iSub ? ~iB : iB;
            cy_q    <= iC ^ iSub;
            res_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oS    = s_q;
  assign oC    = c_q;
  assign oV    = v_q;

endmodule
